axi4_lite_arbiter: RTL
======================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default ADDR_WIDTH from axi4_lite_addr_map_package, meaning the address bus width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default DATA_WIDTH from axi4_lite_addr_map_package, meaning the data bus width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; asynchronous, active-high.
REQ-005 The block SHALL have port m0_if, axi4_lite_if, slave side, carrying requester 0 (instruction fetch, read-only use allowed).
REQ-006 The block SHALL have port m1_if, axi4_lite_if, slave side, carrying requester 1 (data memory).
REQ-007 The block SHALL have port out_if, axi4_lite_if, master side, the unified master port feeding axi4_lite_interconnect.
REQ-008 The block SHALL have port wr_grant, output, 2 bits, the one-hot current write owner (00 = none).
REQ-009 The block SHALL have port rd_grant, output, 2 bits, the one-hot current read owner (00 = none).

Function
REQ-010 Read and write paths SHALL be arbitrated independently, each by its own FSM and round-robin pointer; a read and a write (same or different requesters) SHALL proceed concurrently.
REQ-011 Write FSM states SHALL be W_IDLE, W_ADDR, W_RESP; read FSM states SHALL be R_IDLE, R_ADDR, R_DATA.
REQ-012 The write request of requester n SHALL be AWVALID|WVALID; the read request SHALL be ARVALID.
REQ-013 In W_IDLE/R_IDLE with at least one request, the FSM SHALL register a grant and move to W_ADDR/R_ADDR on the next edge; out_if valids SHALL stay 0 in IDLE (one-cycle arbitration latency).
REQ-014 Round-robin: a single requester SHALL win; if both request, the one not granted last on that channel SHALL win; the pointer SHALL update on every grant.
REQ-015 W_ADDR: the granted AW and W SHALL be routed combinationally to out_if, ready returned only to the owner; the AW and W handshakes SHALL be tracked by flags aw_done and w_done, and a completed channel's valid SHALL be masked to 0 on out_if.
REQ-016 W_ADDR SHALL go to W_RESP in the cycle both flags are set or both handshakes complete, in either order or simultaneously.
REQ-017 W_RESP: out_if.BVALID/BRESP SHALL go to the owner and the owner's BREADY to out_if; on B handshake the FSM SHALL go to W_IDLE, clear flags and drop the grant.
REQ-018 R_ADDR: the owner's ARADDR/ARVALID SHALL be routed; on AR handshake the FSM SHALL go to R_DATA.
REQ-019 R_DATA: RVALID/RDATA/RRESP SHALL go to the owner and the owner's RREADY to out_if; on R handshake the FSM SHALL go to R_IDLE.
REQ-020 A non-owner SHALL see AWREADY, WREADY, BVALID, ARREADY, RVALID = 0 and BRESP, RRESP, RDATA = 0; its requests SHALL be held without loss until granted.
REQ-021 A grant SHALL NOT be revoked before its response handshake completes, regardless of the other requester.
REQ-022 Back-to-back: a request pending at return to IDLE SHALL be granted on the following edge (minimum 1 idle cycle between transactions per channel).
REQ-023 Addresses, data and strobes SHALL pass unmodified; no buffering beyond the grant and flag registers.

Reset
REQ-024 While rst=1 both FSMs SHALL be IDLE, aw_done=w_done=0, wr_grant=rd_grant=00, all out_if valids and readies 0, all requester-side readies and valids 0.
REQ-025 Both round-robin pointers SHALL reset so that requester 0 wins the first simultaneous contest.
REQ-026 Reset asserted mid-transaction SHALL abort immediately to IDLE; no transaction is replayed after release.

Verification
REQ-027 Simultaneous ARVALID from m0 (addr 0x0000_0100) and m1 (0x0000_0200) after reset -> m0 read completes first with its RDATA, then m1; rd_grant 01 then 10.
REQ-028 m1 drives AWVALID one cycle before WVALID, slave returns AWREADY 2 cycles before WREADY -> single write issued, AWVALID low after its handshake, BRESP=00 returned to m1 only.
REQ-029 m0 read and m1 write (WDATA 0xDEAD_BEEF, WSTRB 0xF) started same cycle -> both complete concurrently; rd_grant=01 and wr_grant=10 overlap.
REQ-030 Both masters continuously issue writes for 6 transactions -> grants alternate 01,10,01,10,01,10; no starvation.
REQ-031 Slave holds BVALID low 5 cycles while m0 requests a write and m1 is owner -> m0 sees no ready, m1 grant held until B handshake.
REQ-032 rst pulsed during R_DATA -> rd_grant=00, out_if.RREADY=0 in the same cycle; next m1-only ARVALID is granted normally.

Source files
------------

// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite bus bundle shared by the requester ports and the unified master port.
// The master modport is the bus initiator. The slave modport is the responder side.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter with independent round-robin read and write paths.
// Only the grant, ownership and handshake-flag registers are stored; the datapath is pure muxing.
//
// state  | meaning
// W_IDLE | no write owner, arbitrating AWVALID|WVALID
// W_ADDR | owner's AW and W routed, waiting for both handshakes
// W_RESP | waiting for B handshake to the owner
// R_IDLE | no read owner, arbitrating ARVALID
// R_ADDR | owner's AR routed, waiting for AR handshake
// R_DATA | waiting for R handshake to the owner
package axi4_lite_addr_map_package;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

module axi4_lite_arbiter #(
    parameter int ADDR_WIDTH = axi4_lite_addr_map_package::ADDR_WIDTH,
    parameter int DATA_WIDTH = axi4_lite_addr_map_package::DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    axi4_lite_if.slave      m0_if,
    axi4_lite_if.slave      m1_if,
    axi4_lite_if.master     out_if,
    output logic [1:0]      wr_grant,
    output logic [1:0]      rd_grant
);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic     w_own_q, w_own_d, w_last_q, w_last_d;
    logic     r_own_q, r_own_d, r_last_q, r_last_d;
    logic     aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic                    m0_wreq, m1_wreq;
    logic                    sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic [ADDR_WIDTH-1:0]   sel_awaddr, sel_araddr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_wstrb;
    logic                    o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
    logic                    g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
    logic [1:0]              g_bresp, g_rresp;
    logic [DATA_WIDTH-1:0]   g_rdata;
    logic                    aw_hs, w_hs;

    // Pointer holds the last winner; resetting it to 1 lets requester 0 win the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_own_q   <= 1'b0;
            w_last_q  <= 1'b1;
            r_own_q   <= 1'b0;
            r_last_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_own_q   <= w_own_d;
            w_last_q  <= w_last_d;
            r_own_q   <= r_own_d;
            r_last_q  <= r_last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign m0_wreq     = m0_if.awvalid | m0_if.wvalid;
    assign m1_wreq     = m1_if.awvalid | m1_if.wvalid;
    assign sel_awvalid = w_own_q ? m1_if.awvalid : m0_if.awvalid;
    assign sel_wvalid  = w_own_q ? m1_if.wvalid  : m0_if.wvalid;
    assign sel_bready  = w_own_q ? m1_if.bready  : m0_if.bready;
    assign sel_awaddr  = w_own_q ? m1_if.awaddr  : m0_if.awaddr;
    assign sel_wdata   = w_own_q ? m1_if.wdata   : m0_if.wdata;
    assign sel_wstrb   = w_own_q ? m1_if.wstrb   : m0_if.wstrb;
    assign sel_arvalid = r_own_q ? m1_if.arvalid : m0_if.arvalid;
    assign sel_rready  = r_own_q ? m1_if.rready  : m0_if.rready;
    assign sel_araddr  = r_own_q ? m1_if.araddr  : m0_if.araddr;

    always_comb begin
        w_state_d = w_state_q;
        w_own_d   = w_own_q;
        w_last_d  = w_last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        o_awvalid = 1'b0;
        o_wvalid  = 1'b0;
        o_bready  = 1'b0;
        g_awready = 1'b0;
        g_wready  = 1'b0;
        g_bvalid  = 1'b0;
        g_bresp   = 2'b00;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (m0_wreq || m1_wreq) begin
                    w_own_d   = (m0_wreq && m1_wreq) ? ~w_last_q : m1_wreq;
                    w_last_d  = w_own_d;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                // A channel that already handshook is masked so it cannot issue twice.
                o_awvalid = sel_awvalid & ~aw_done_q;
                o_wvalid  = sel_wvalid & ~w_done_q;
                g_awready = out_if.awready & ~aw_done_q;
                g_wready  = out_if.wready & ~w_done_q;
                aw_hs     = o_awvalid & out_if.awready;
                w_hs      = o_wvalid & out_if.wready;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                o_bready = sel_bready;
                g_bvalid = out_if.bvalid;
                g_bresp  = out_if.bresp;
                if (out_if.bvalid && sel_bready) begin
                    w_state_d = W_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_own_d   = r_own_q;
        r_last_d  = r_last_q;
        o_arvalid = 1'b0;
        o_rready  = 1'b0;
        g_arready = 1'b0;
        g_rvalid  = 1'b0;
        g_rresp   = 2'b00;
        g_rdata   = '0;
        case (r_state_q)
            R_IDLE: begin
                if (m0_if.arvalid || m1_if.arvalid) begin
                    r_own_d   = (m0_if.arvalid && m1_if.arvalid) ? ~r_last_q : m1_if.arvalid;
                    r_last_d  = r_own_d;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                o_arvalid = sel_arvalid;
                g_arready = out_if.arready;
                if (sel_arvalid && out_if.arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                o_rready = sel_rready;
                g_rvalid = out_if.rvalid;
                g_rresp  = out_if.rresp;
                g_rdata  = out_if.rdata;
                if (out_if.rvalid && sel_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m0_if.awready = g_awready & ~w_own_q;
        m1_if.awready = g_awready & w_own_q;
        m0_if.wready  = g_wready & ~w_own_q;
        m1_if.wready  = g_wready & w_own_q;
        m0_if.bvalid  = g_bvalid & ~w_own_q;
        m1_if.bvalid  = g_bvalid & w_own_q;
        m0_if.bresp   = w_own_q ? 2'b00 : g_bresp;
        m1_if.bresp   = w_own_q ? g_bresp : 2'b00;
        m0_if.arready = g_arready & ~r_own_q;
        m1_if.arready = g_arready & r_own_q;
        m0_if.rvalid  = g_rvalid & ~r_own_q;
        m1_if.rvalid  = g_rvalid & r_own_q;
        m0_if.rresp   = r_own_q ? 2'b00 : g_rresp;
        m1_if.rresp   = r_own_q ? g_rresp : 2'b00;
        m0_if.rdata   = r_own_q ? '0 : g_rdata;
        m1_if.rdata   = r_own_q ? g_rdata : '0;
    end

    assign out_if.awvalid = o_awvalid;
    assign out_if.awaddr  = sel_awaddr;
    assign out_if.wvalid  = o_wvalid;
    assign out_if.wdata   = sel_wdata;
    assign out_if.wstrb   = sel_wstrb;
    assign out_if.bready  = o_bready;
    assign out_if.arvalid = o_arvalid;
    assign out_if.araddr  = sel_araddr;
    assign out_if.rready  = o_rready;

    assign wr_grant = (w_state_q == W_IDLE) ? 2'b00 : {w_own_q, ~w_own_q};
    assign rd_grant = (r_state_q == R_IDLE) ? 2'b00 : {r_own_q, ~r_own_q};
endmodule
